dcache_miss_sequencer: RTL and testbench
========================================

DCACHE_MISS_SEQUENCER -- requirements
Module: dcache_miss_sequencer

Interface
REQ-001 SHALL have parameter SRAM_LAT, default 2, meaning tag/data SRAM read latency in cycles from read enable to data valid.
REQ-002 SHALL have parameter IDX_W, default 8, meaning set index width (256 sets); TAG_W = 20; block = 128 bits; metadata = {tag[21:2], dirty[1], valid[0]}, 22 bits.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 miss_valid  in  1  cache controller requests a block repair.
REQ-006 miss_addr  in  32  missed byte address: offset [3:0], index [11:4], tag [31:12].
REQ-007 miss_ready  out  1  sequencer can accept a miss this cycle.
REQ-008 repair_resolved  out  1  one-cycle pulse when the block is installed.
REQ-009 meta_rd_en / meta_rd_idx / meta_rd_data  out 1 / out 8 / in 22  tag-store read port.
REQ-010 meta_wr_en / meta_wr_idx / meta_wr_data  out 1 / out 8 / out 22  tag-store write port.
REQ-011 data_rd_en / data_rd_idx / data_rd_data  out 1 / out 8 / in 128  data-store read port (victim read).
REQ-012 data_wr_en / data_wr_idx / data_wr_data / data_wr_mask  out 1 / out 8 / out 128 / out 16  data-store write port.
REQ-013 mem_req_valid / mem_req_ready / mem_req_we / mem_req_addr / mem_req_wdata  out 1 / in 1 / out 1 / out 32 / out 128  block request to memory.
REQ-014 mem_resp_valid / mem_resp_rdata  in 1 / in 128  memory response; one response per accepted request, read or write.

Function
REQ-015 States SHALL be INIT, IDLE, META_RD, EVICT_RD, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, INSTALL, DONE.
REQ-016 INIT: sweep counter 0..255, one meta write per cycle, meta_wr_data = 0; go to IDLE after index 255 is written.
REQ-017 miss_ready SHALL be 1 only in IDLE; on miss_valid && miss_ready, latch miss_addr and go to META_RD.
REQ-018 META_RD: meta_rd_en = 1 for the first cycle only, idx = latched index; sample meta_rd_data SRAM_LAT cycles later.
REQ-019 META_RD exit: valid && dirty -> EVICT_RD; otherwise -> FILL_REQ. Victim tag is latched.
REQ-020 EVICT_RD: data_rd_en pulsed once; data_rd_data captured SRAM_LAT cycles later as writeback data -> WB_REQ.
REQ-021 WB_REQ: mem_req_valid = 1, we = 1, addr = {victim tag, idx, 4'h0}, wdata = captured victim; on mem_req_ready -> WB_WAIT.
REQ-022 WB_WAIT: wait for mem_resp_valid -> FILL_REQ.
REQ-023 FILL_REQ: mem_req_valid = 1, we = 0, addr = {miss_addr[31:4], 4'h0}; on mem_req_ready -> FILL_WAIT.
REQ-024 FILL_WAIT: on mem_resp_valid capture mem_resp_rdata -> INSTALL.
REQ-025 INSTALL: one cycle with data_wr_en = 1, mask = 16'hFFFF, data = fill; meta_wr_en = 1, data = {miss tag, 0, 1} -> DONE.
REQ-026 DONE: repair_resolved = 1 for exactly one cycle -> IDLE.
REQ-027 Valid/ready: while mem_req_valid is high and ready is low, mem_req_we, addr and wdata SHALL be held stable; a request is accepted in the first cycle valid && ready; ready may already be high when valid rises.
REQ-028 mem_resp_valid outside WB_WAIT/FILL_WAIT SHALL be ignored; a response is never expected in the same cycle as request acceptance.
REQ-029 miss_valid while busy SHALL NOT be accepted; the requester holds, and it is accepted in the first IDLE cycle.
REQ-030 All enables SHALL be 0 in states not listed for them; at most one meta write and one data write per cycle.

Reset
REQ-031 rst in any state SHALL force INIT, sweep counter = 0, and all outputs = 0 except the INIT meta writes. An in-flight repair is abandoned without repair_resolved.
REQ-032 After rst deasserts, miss_ready SHALL stay 0 for 256 cycles and rise on cycle 257.

Verification
V-1 Release rst -> meta writes to idx 0x00..0xFF with data 0, one per cycle; miss_ready = 1 on the following cycle.
V-2 Set 0x23 invalid; miss_addr 0x0000_1234 -> single mem read to 0x0000_1230, no write; INSTALL writes idx 0x23, meta 0x00001 tag, dirty 0, valid 1, mask FFFF; one-cycle repair_resolved.
V-3 Set 0x23 meta tag 0xABCDE, dirty, valid; data = D; miss 0x0000_1234 -> write to 0xABCD_E230 with wdata D, then read to 0x0000_1230, then install.
V-4 mem_req_ready low 5 cycles in WB_REQ and FILL_REQ -> valid, we, addr, wdata constant; exactly one acceptance each.
V-5 rst asserted in FILL_WAIT, stray mem_resp_valid after -> no repair_resolved, no install write, full INIT sweep repeats.
V-6 Second miss_valid held during repair -> miss_ready = 0 until the cycle after the repair_resolved pulse; the second miss is accepted then.

Source files
------------

// File: rtl/dcache_miss_sequencer.sv
// Data-cache miss sequencer: sweeps the tag store clean after reset, then repairs one missing
// block at a time (tag lookup, optional dirty-victim writeback, fill, install).
module dcache_miss_sequencer #(
  parameter int unsigned SRAM_LAT = 2,
  parameter int unsigned IDX_W    = 8,
  localparam int unsigned TAG_W   = 28 - IDX_W,
  localparam int unsigned META_W  = TAG_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [31:0]       miss_addr,
  output logic              miss_ready,
  output logic              repair_resolved,
  output logic              meta_rd_en,
  output logic [IDX_W-1:0]  meta_rd_idx,
  input  logic [META_W-1:0] meta_rd_data,
  output logic              meta_wr_en,
  output logic [IDX_W-1:0]  meta_wr_idx,
  output logic [META_W-1:0] meta_wr_data,
  output logic              data_rd_en,
  output logic [IDX_W-1:0]  data_rd_idx,
  input  logic [127:0]      data_rd_data,
  output logic              data_wr_en,
  output logic [IDX_W-1:0]  data_wr_idx,
  output logic [127:0]      data_wr_data,
  output logic [15:0]       data_wr_mask,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [31:0]       mem_req_addr,
  output logic [127:0]      mem_req_wdata,
  input  logic              mem_resp_valid,
  input  logic [127:0]      mem_resp_rdata
);

  localparam logic [IDX_W-1:0] LAT = IDX_W'(SRAM_LAT);

  typedef enum logic [3:0] {
    StInit, StIdle, StMetaRd, StEvictRd, StWbReq, StWbWait, StFillReq, StFillWait, StInstall, StDone
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [TAG_W-1:0]   vtag_q, vtag_d;
  logic [127:0]       vdata_q, vdata_d;
  logic [127:0]       fill_q, fill_d;
  logic [IDX_W-1:0]   idx_d;

  // cnt doubles as the INIT sweep index and the SRAM latency timer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    vtag_d  = vtag_q;
    vdata_d = vdata_q;
    fill_d  = fill_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = StIdle;
      end
      StIdle: begin
        if (miss_valid && miss_ready) begin
          addr_d  = miss_addr;
          cnt_d   = '0;
          state_d = StMetaRd;
        end
      end
      StMetaRd: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT) begin
          vtag_d  = meta_rd_data[META_W-1:2];
          cnt_d   = '0;
          state_d = (meta_rd_data[1] && meta_rd_data[0]) ? StEvictRd : StFillReq;
        end
      end
      StEvictRd: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAT) begin
          vdata_d = data_rd_data;
          cnt_d   = '0;
          state_d = StWbReq;
        end
      end
      StWbReq:    if (mem_req_ready) state_d = StWbWait;
      StWbWait:   if (mem_resp_valid) state_d = StFillReq;
      StFillReq:  if (mem_req_ready) state_d = StFillWait;
      StFillWait: begin
        if (mem_resp_valid) begin
          fill_d  = mem_resp_rdata;
          state_d = StInstall;
        end
      end
      StInstall:  state_d = StDone;
      StDone:     state_d = StIdle;
      default:    state_d = StInit;
    endcase
  end

  assign idx_d = addr_d[4 +: IDX_W];

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StInit;
      cnt_q           <= '0;
      addr_q          <= '0;
      vtag_q          <= '0;
      vdata_q         <= '0;
      fill_q          <= '0;
      miss_ready      <= 1'b0;
      repair_resolved <= 1'b0;
      meta_rd_en      <= 1'b0;
      meta_rd_idx     <= '0;
      meta_wr_en      <= 1'b1;
      meta_wr_idx     <= '0;
      meta_wr_data    <= '0;
      data_rd_en      <= 1'b0;
      data_rd_idx     <= '0;
      data_wr_en      <= 1'b0;
      data_wr_idx     <= '0;
      data_wr_data    <= '0;
      data_wr_mask    <= '0;
      mem_req_valid   <= 1'b0;
      mem_req_we      <= 1'b0;
      mem_req_addr    <= '0;
      mem_req_wdata   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      addr_q          <= addr_d;
      vtag_q          <= vtag_d;
      vdata_q         <= vdata_d;
      fill_q          <= fill_d;
      miss_ready      <= (state_d == StIdle);
      repair_resolved <= (state_d == StDone);
      meta_rd_en      <= (state_d == StMetaRd) && (cnt_d == '0);
      meta_rd_idx     <= (state_d == StMetaRd) ? idx_d : '0;
      meta_wr_en      <= (state_d == StInit) || (state_d == StInstall);
      meta_wr_idx     <= (state_d == StInit) ? cnt_d : (state_d == StInstall) ? idx_d : '0;
      meta_wr_data    <= (state_d == StInstall) ? {addr_d[31 -: TAG_W], 1'b0, 1'b1} : '0;
      data_rd_en      <= (state_d == StEvictRd) && (cnt_d == '0);
      data_rd_idx     <= (state_d == StEvictRd) ? idx_d : '0;
      data_wr_en      <= (state_d == StInstall);
      data_wr_idx     <= (state_d == StInstall) ? idx_d : '0;
      data_wr_data    <= (state_d == StInstall) ? fill_d : '0;
      data_wr_mask    <= (state_d == StInstall) ? 16'hFFFF : 16'h0000;
      mem_req_valid   <= (state_d == StWbReq) || (state_d == StFillReq);
      mem_req_we      <= (state_d == StWbReq);
      mem_req_addr    <= (state_d == StWbReq)   ? {vtag_d, idx_d, 4'h0} :
                         (state_d == StFillReq) ? {addr_d[31:4], 4'h0} : 32'h0;
      mem_req_wdata   <= (state_d == StWbReq) ? vdata_d : '0;
    end
  end

endmodule

// File: tb/tb_dcache_miss_sequencer.sv
// Bench for dcache_miss_sequencer: SRAM and memory models, table of miss vectors with a
// scoreboard of expected memory requests, plus hand-written reset and back-to-back sequences.
module tb_dcache_miss_sequencer;

  localparam int LAT = 2;

  logic         clk, rst, miss_valid, miss_ready, repair_resolved;
  logic [31:0]  miss_addr;
  logic         meta_rd_en, meta_wr_en, data_rd_en, data_wr_en;
  logic [7:0]   meta_rd_idx, meta_wr_idx, data_rd_idx, data_wr_idx;
  logic [21:0]  meta_rd_data, meta_wr_data;
  logic [127:0] data_rd_data, data_wr_data, mem_req_wdata, mem_resp_rdata;
  logic [15:0]  data_wr_mask;
  logic         mem_req_valid, mem_req_ready, mem_req_we, mem_resp_valid;
  logic [31:0]  mem_req_addr;

  dcache_miss_sequencer #(.SRAM_LAT(LAT), .IDX_W(8)) dut (
    .clk(clk), .rst(rst), .miss_valid(miss_valid), .miss_addr(miss_addr),
    .miss_ready(miss_ready), .repair_resolved(repair_resolved),
    .meta_rd_en(meta_rd_en), .meta_rd_idx(meta_rd_idx), .meta_rd_data(meta_rd_data),
    .meta_wr_en(meta_wr_en), .meta_wr_idx(meta_wr_idx), .meta_wr_data(meta_wr_data),
    .data_rd_en(data_rd_en), .data_rd_idx(data_rd_idx), .data_rd_data(data_rd_data),
    .data_wr_en(data_wr_en), .data_wr_idx(data_wr_idx), .data_wr_data(data_wr_data),
    .data_wr_mask(data_wr_mask), .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: read data appears LAT cycles after the enable.
  logic [21:0]  meta_mem [256];
  logic [127:0] data_mem [256];
  logic [21:0]  mpipe [LAT];
  logic [127:0] dpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= meta_rd_en ? meta_mem[meta_rd_idx] : 22'h0;
    dpipe[0] <= data_rd_en ? data_mem[data_rd_idx] : 128'h0;
    for (int i = 1; i < LAT; i++) begin
      mpipe[i] <= mpipe[i-1];
      dpipe[i] <= dpipe[i-1];
    end
  end
  assign meta_rd_data = mpipe[LAT-1];
  assign data_rd_data = dpipe[LAT-1];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0]  addr;
    logic         v, d;
    logic [19:0]  tag;
    logic [127:0] victim, fill;
    int           rdly;       // ready low cycles per request; -1 keeps ready high throughout
    logic         wb;
    logic [31:0]  wb_addr, fill_addr;
    logic [21:0]  meta;
  } vec_t;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [127:0] wdata;
  } mreq_t;

  vec_t  vt [8];
  mreq_t exp_q [$];

  task automatic sweep(input int stray);
    int bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) @(negedge clk);
      mem_resp_valid = (i < stray);
      if (meta_wr_en !== 1'b1 || meta_wr_idx !== i[7:0] || meta_wr_data !== 22'h0 ||
          miss_ready !== 1'b0 || repair_resolved !== 1'b0 || data_wr_en !== 1'b0 ||
          mem_req_valid !== 1'b0 || meta_rd_en !== 1'b0 || data_rd_en !== 1'b0) bad++;
    end
    mem_resp_valid = 1'b0;
    chk("init_sweep_bad_cycles", 128'(bad), 128'(0));
    @(negedge clk);
    chk("ready_after_sweep", 128'(miss_ready), 128'(1));
    chk("no_meta_wr_after_sweep", 128'(meta_wr_en), 128'(0));
  endtask

  task automatic do_miss(input vec_t v, input bit pre, input bit hold, input logic [31:0] haddr);
    int    nacc = 0, ninst = 0, busy_bad = 0, wait_cnt = 0, resp_timer = 0;
    bit    accepted = pre, drop = pre, seen = 0, done = 0, in_req = 0;
    mreq_t snap, e;
    logic [127:0] resp_data = '0;
    logic [7:0]   idx = v.addr[11:4];
    meta_mem[idx] = {v.tag, v.d, v.v};
    data_mem[idx] = v.victim;
    if (v.wb) exp_q.push_back('{1'b1, v.wb_addr, v.victim});
    exp_q.push_back('{1'b0, v.fill_addr, 128'h0});
    mem_req_ready = (v.rdly < 0);
    if (pre) @(negedge clk);
    else begin
      miss_valid = 1'b1;
      miss_addr  = v.addr;
    end
    for (int c = 0; c < 400 && !done; c++) begin
      if (drop) begin
        if (hold) miss_addr = haddr;
        else miss_valid = 1'b0;
        drop = 0;
      end
      if (seen) begin
        chk("single_pulse", 128'(repair_resolved), 128'(0));
        chk("ready_after_done", 128'(miss_ready), 128'(1));
        done = 1;
      end else begin
        if (accepted && miss_ready) busy_bad++;
        if (!accepted && miss_valid && miss_ready) begin
          accepted = 1;
          drop = 1;
        end
        mem_resp_valid = 1'b0;
        if (resp_timer > 0) begin
          resp_timer--;
          if (resp_timer == 0) begin
            mem_resp_valid = 1'b1;
            mem_resp_rdata = resp_data;
          end
        end
        if (mem_req_valid) begin
          if (!in_req) begin
            snap   = '{mem_req_we, mem_req_addr, mem_req_wdata};
            in_req = 1;
          end else begin
            chk("hold_we", 128'(mem_req_we), 128'(snap.we));
            chk("hold_addr", 128'(mem_req_addr), 128'(snap.addr));
            chk("hold_wdata", mem_req_wdata, snap.wdata);
          end
          if (v.rdly >= 0 && wait_cnt < v.rdly) begin
            mem_req_ready = 1'b0;
            wait_cnt++;
          end else begin
            mem_req_ready = 1'b1;
            wait_cnt = 0;
            in_req = 0;
            nacc++;
            if (exp_q.size() == 0) chk("unexpected_mem_req", 128'(1), 128'(0));
            else begin
              e = exp_q.pop_front();
              chk("req_we", 128'(mem_req_we), 128'(e.we));
              chk("req_addr", 128'(mem_req_addr), 128'(e.addr));
              if (e.we) chk("req_wdata", mem_req_wdata, e.wdata);
            end
            resp_timer = 2;
            resp_data  = mem_req_we ? 128'h0 : v.fill;
          end
        end else mem_req_ready = (v.rdly < 0);
        if (data_wr_en) begin
          ninst++;
          chk("inst_idx", 128'(data_wr_idx), 128'(idx));
          chk("inst_data", data_wr_data, v.fill);
          chk("inst_mask", 128'(data_wr_mask), 128'(16'hFFFF));
          chk("inst_meta_en", 128'(meta_wr_en), 128'(1));
          chk("inst_meta_idx", 128'(meta_wr_idx), 128'(idx));
          chk("inst_meta_data", 128'(meta_wr_data), 128'(v.meta));
        end else if (meta_wr_en) chk("stray_meta_write", 128'(1), 128'(0));
        if (repair_resolved) seen = 1;
        @(negedge clk);
      end
    end
    mem_resp_valid = 1'b0;
    mem_req_ready  = 1'b0;
    chk("repair_timeout", 128'(done), 128'(1));
    chk("mem_accept_count", 128'(nacc), 128'(v.wb ? 2 : 1));
    chk("install_count", 128'(ninst), 128'(1));
    chk("ready_low_while_busy", 128'(busy_bad), 128'(0));
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    exp_q.delete();
  endtask

  task automatic reset_check(input string name);
    chk(name, 128'({miss_ready, repair_resolved, meta_rd_en, data_rd_en, data_wr_en,
                    mem_req_valid, meta_wr_en, meta_wr_idx, meta_wr_data}),
        128'({6'b0, 1'b1, 8'h00, 22'h0}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h0000_1234, 1'b0, 1'b0, 20'h0, 128'h0,
              128'h0F0E0D0C_0B0A0908_07060504_03020100, 0, 1'b0, 32'h0,
              32'h0000_1230, 22'h000005};
    vt[1] = '{32'h0000_1234, 1'b1, 1'b1, 20'hABCDE, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF,
              128'h11112222_33334444_55556666_77778888, 0, 1'b1, 32'hABCD_E230,
              32'h0000_1230, 22'h000005};
    vt[2] = '{32'hDEAD_BEEF, 1'b1, 1'b1, 20'h12345, {4{32'hA5A5_5A5A}}, {4{32'h3C3C_C3C3}},
              5, 1'b1, 32'h1234_5EE0, 32'hDEAD_BEE0, 22'h37AB6D};
    vt[3] = '{32'hFFFF_FFF0, 1'b1, 1'b0, 20'h11111, {4{32'h1111_1111}}, {4{32'hFEDC_BA98}},
              -1, 1'b0, 32'h0, 32'hFFFF_FFF0, 22'h3FFFFD};
    vt[4] = '{32'h0000_0008, 1'b1, 1'b1, 20'hFFFFF, {4{32'h0BAD_F00D}}, {4{32'h7654_3210}},
              3, 1'b1, 32'hFFFF_F000, 32'h0000_0000, 22'h000001};
    vt[5] = '{32'h8000_0450, 1'b0, 1'b1, 20'h2AAAA, {4{32'h5555_AAAA}}, {4{32'h0000_FFFF}},
              0, 1'b0, 32'h0, 32'h8000_0450, 22'h200001};
    vt[6] = '{32'h0000_5670, 1'b0, 1'b0, 20'h0, 128'h0, {4{32'h6666_7777}},
              1, 1'b0, 32'h0, 32'h0000_5670, 22'h000015};
    vt[7] = '{32'h0000_9AB0, 1'b1, 1'b1, 20'h77777, {4{32'h9999_8888}}, {4{32'hABAB_CDCD}},
              2, 1'b1, 32'h7777_7AB0, 32'h0000_9AB0, 22'h000025};

    rst = 1'b1;
    miss_valid = 1'b0;
    miss_addr = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = '0;
    for (int i = 0; i < 256; i++) begin
      meta_mem[i] = '0;
      data_mem[i] = '0;
    end
    repeat (3) @(negedge clk);
    reset_check("reset_state");
    rst = 1'b0;
    sweep(0);

    for (int i = 0; i < 6; i++) do_miss(vt[i], 1'b0, 1'b0, 32'h0);

    // Second miss held during a repair is taken the cycle after repair_resolved.
    do_miss(vt[6], 1'b0, 1'b1, vt[7].addr);
    do_miss(vt[7], 1'b1, 1'b0, 32'h0);

    // Reset while waiting for fill data; a stray response afterwards must be ignored.
    begin
      bit found = 0;
      int bad = 0;
      meta_mem[8'h23] = '0;
      miss_valid = 1'b1;
      miss_addr  = 32'h0000_1234;
      @(negedge clk);
      miss_valid = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        if (mem_req_valid) found = 1;
        else @(negedge clk);
      end
      chk("v5_fill_req_seen", 128'(found), 128'(1));
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) begin
        @(negedge clk);
        mem_resp_valid = 1'b1;
        if (repair_resolved !== 1'b0 || data_wr_en !== 1'b0 || miss_ready !== 1'b0) bad++;
      end
      chk("v5_quiet_in_reset", 128'(bad), 128'(0));
      reset_check("v5_reset_state");
      rst = 1'b0;
      sweep(4);
    end

    do_miss(vt[0], 1'b0, 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
